ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 164 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with operand forwarding, branch/jump redirect and the EX/MEM pipeline register
module ex_mem_stage #(
    parameter int datawidth = 32,
    parameter int regindex  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [regindex-1:0]  IFIDreg1_out,
    input  logic [regindex-1:0]  IFIDreg2_out,
    input  logic [regindex-1:0]  IFIDregd_out,
    input  logic [datawidth-1:0] datareg1_out,
    input  logic [datawidth-1:0] datareg2_out,
    input  logic [datawidth-1:0] pcx_out,
    input  logic [datawidth-1:0] imm_out,
    input  logic [3:0]           ALUsel_out,
    input  logic                 Asel_out,
    input  logic                 Bsel_out,
    input  logic [2:0]           Rsel_out,
    input  logic [1:0]           Wbsel_out,
    input  logic                 MemRw_out,
    input  logic [1:0]           Wsel_out,
    input  logic                 IF_ID_Regwrite_out,
    input  logic [4:0]           ID_EX_Opcode,
    input  logic [regindex-1:0]  wb_rd,
    input  logic                 wb_regwrite,
    input  logic [datawidth-1:0] wb_data,
    output logic                 stall_out,
    output logic                 redirect_valid,
    output logic [datawidth-1:0] redirect_pc,
    output logic [datawidth-1:0] exmem_alu,
    output logic [datawidth-1:0] exmem_wdata,
    output logic [datawidth-1:0] exmem_pc4,
    output logic [regindex-1:0]  exmem_rd,
    output logic                 exmem_regwrite,
    output logic                 exmem_memrw,
    output logic [1:0]           exmem_wbsel,
    output logic [1:0]           exmem_wsel
);

    localparam logic [4:0] op_branch = 5'b11000;
    localparam logic [4:0] op_jal    = 5'b11011;
    localparam logic [4:0] op_jalr   = 5'b11001;

    logic                 ex_fwd_ok, wb_fwd_ok;
    logic [datawidth-1:0] ex_fwd_val;
    logic [datawidth-1:0] fwd_rs1, fwd_rs2;
    logic [datawidth-1:0] alu_a, alu_b, alu_res;
    logic [4:0]           shamt;
    logic                 br_taken;
    logic                 redirect_cond;
    logic [datawidth-1:0] redirect_target;
    logic [datawidth-1:0] jalr_sum;

    // A load result (wbsel 00) is not available yet, so it is never forwarded from EX/MEM.
    assign ex_fwd_ok  = exmem_regwrite && (exmem_rd != '0) && (exmem_wbsel != 2'b00);
    assign wb_fwd_ok  = wb_regwrite && (wb_rd != '0);
    assign ex_fwd_val = (exmem_wbsel == 2'b10) ? exmem_pc4 : exmem_alu;

    always_comb begin
        fwd_rs1 = datareg1_out;
        if (ex_fwd_ok && (exmem_rd == IFIDreg1_out))
            fwd_rs1 = ex_fwd_val;
        else if (wb_fwd_ok && (wb_rd == IFIDreg1_out))
            fwd_rs1 = wb_data;

        fwd_rs2 = datareg2_out;
        if (ex_fwd_ok && (exmem_rd == IFIDreg2_out))
            fwd_rs2 = ex_fwd_val;
        else if (wb_fwd_ok && (wb_rd == IFIDreg2_out))
            fwd_rs2 = wb_data;
    end

    assign alu_a = Asel_out ? pcx_out : fwd_rs1;
    assign alu_b = Bsel_out ? imm_out : fwd_rs2;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        case (ALUsel_out)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0001: alu_res = alu_a - alu_b;
            4'b0010: alu_res = alu_a << shamt;
            4'b0011: alu_res = {{(datawidth-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'b0100: alu_res = {{(datawidth-1){1'b0}}, (alu_a < alu_b)};
            4'b0101: alu_res = alu_a ^ alu_b;
            4'b0110: alu_res = alu_a >> shamt;
            4'b0111: alu_res = $signed(alu_a) >>> shamt;
            4'b1000: alu_res = alu_a | alu_b;
            4'b1001: alu_res = alu_a & alu_b;
            4'b1010: alu_res = alu_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (Rsel_out)
            3'b000:  br_taken = (fwd_rs1 == fwd_rs2);
            3'b001:  br_taken = (fwd_rs1 != fwd_rs2);
            3'b100:  br_taken = ($signed(fwd_rs1) < $signed(fwd_rs2));
            3'b101:  br_taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            3'b110:  br_taken = (fwd_rs1 < fwd_rs2);
            3'b111:  br_taken = (fwd_rs1 >= fwd_rs2);
            default: br_taken = 1'b0;
        endcase
    end

    assign jalr_sum = fwd_rs1 + imm_out;

    always_comb begin
        redirect_cond   = 1'b0;
        redirect_target = pcx_out + imm_out;
        if (ID_EX_Opcode == op_branch)
            redirect_cond = br_taken;
        else if (ID_EX_Opcode == op_jal)
            redirect_cond = 1'b1;
        else if (ID_EX_Opcode == op_jalr) begin
            redirect_cond   = 1'b1;
            redirect_target = jalr_sum & ~datawidth'(1);
        end
    end

    assign stall_out = exmem_regwrite && (exmem_wbsel == 2'b00) && (exmem_rd != '0) &&
                       ((exmem_rd == IFIDreg1_out) || (exmem_rd == IFIDreg2_out));

    assign redirect_valid = redirect_cond && en && !stall_out;
    assign redirect_pc    = redirect_valid ? redirect_target : '0;

    // A stalled cycle inserts a bubble; the load then reaches WB and feeds the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_alu      <= '0;
            exmem_wdata    <= '0;
            exmem_pc4      <= '0;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            exmem_memrw    <= 1'b0;
            exmem_wbsel    <= 2'b00;
            exmem_wsel     <= 2'b00;
        end else if (en) begin
            if (stall_out) begin
                exmem_alu      <= '0;
                exmem_wdata    <= '0;
                exmem_pc4      <= '0;
                exmem_rd       <= '0;
                exmem_regwrite <= 1'b0;
                exmem_memrw    <= 1'b0;
                exmem_wbsel    <= 2'b00;
                exmem_wsel     <= 2'b00;
            end else begin
                exmem_alu      <= alu_res;
                exmem_wdata    <= fwd_rs2;
                exmem_pc4      <= pcx_out + datawidth'(4);
                exmem_rd       <= IFIDregd_out;
                exmem_regwrite <= IF_ID_Regwrite_out;
                exmem_memrw    <= MemRw_out;
                exmem_wbsel    <= Wbsel_out;
                exmem_wsel     <= Wsel_out;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memrw;
        logic [1:0]  wbsel;
        logic [1:0]  wsel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [4:0]  IFIDreg1_out, IFIDreg2_out, IFIDregd_out;
    logic [31:0] datareg1_out, datareg2_out, pcx_out, imm_out;
    logic [3:0]  ALUsel_out;
    logic        Asel_out, Bsel_out;
    logic [2:0]  Rsel_out;
    logic [1:0]  Wbsel_out;
    logic        MemRw_out;
    logic [1:0]  Wsel_out;
    logic        IF_ID_Regwrite_out;
    logic [4:0]  ID_EX_Opcode;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic        stall_out, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] exmem_alu, exmem_wdata, exmem_pc4;
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite, exmem_memrw;
    logic [1:0]  exmem_wbsel, exmem_wsel;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp, last, act;

    localparam logic [3:0]  alu_sel_tab [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                                 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
    localparam logic [31:0] alu_exp_tab [12] = '{32'hF0000027, 32'hEFFFFFDF, 32'h00000030,
                                                 32'h00000001, 32'h00000000, 32'hF0000027,
                                                 32'h0F000000, 32'hFF000000, 32'hF0000027,
                                                 32'h00000000, 32'h00000024, 32'h00000000};
    // rs1=-1, rs2=1 against every Rsel encoding
    localparam logic        br_exp_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    assign act = '{alu: exmem_alu, wdata: exmem_wdata, pc4: exmem_pc4, rd: exmem_rd,
                   regwrite: exmem_regwrite, memrw: exmem_memrw, wbsel: exmem_wbsel,
                   wsel: exmem_wsel};

    ex_mem_stage #(.datawidth(32), .regindex(5)) dut (
        .clk(clk), .rst(rst), .en(en),
        .IFIDreg1_out(IFIDreg1_out), .IFIDreg2_out(IFIDreg2_out), .IFIDregd_out(IFIDregd_out),
        .datareg1_out(datareg1_out), .datareg2_out(datareg2_out),
        .pcx_out(pcx_out), .imm_out(imm_out),
        .ALUsel_out(ALUsel_out), .Asel_out(Asel_out), .Bsel_out(Bsel_out),
        .Rsel_out(Rsel_out), .Wbsel_out(Wbsel_out), .MemRw_out(MemRw_out),
        .Wsel_out(Wsel_out), .IF_ID_Regwrite_out(IF_ID_Regwrite_out),
        .ID_EX_Opcode(ID_EX_Opcode),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
        .stall_out(stall_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exmem_alu(exmem_alu), .exmem_wdata(exmem_wdata), .exmem_pc4(exmem_pc4),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memrw(exmem_memrw),
        .exmem_wbsel(exmem_wbsel), .exmem_wsel(exmem_wsel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en = 1'b1;
        IFIDreg1_out = '0; IFIDreg2_out = '0; IFIDregd_out = '0;
        datareg1_out = '0; datareg2_out = '0; pcx_out = '0; imm_out = '0;
        ALUsel_out = '0; Asel_out = 1'b0; Bsel_out = 1'b0; Rsel_out = '0;
        Wbsel_out = '0; MemRw_out = 1'b0; Wsel_out = '0; IF_ID_Regwrite_out = 1'b0;
        ID_EX_Opcode = '0; wb_rd = '0; wb_regwrite = 1'b0; wb_data = '0;
    endtask

    task automatic set_rr(input logic [3:0] sel, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] pc);
        ALUsel_out = sel; IFIDreg1_out = rs1; IFIDreg2_out = rs2; IFIDregd_out = rd;
        datareg1_out = d1; datareg2_out = d2; pcx_out = pc;
        Asel_out = 1'b0; Bsel_out = 1'b0; Wbsel_out = 2'b01; MemRw_out = 1'b0;
        IF_ID_Regwrite_out = 1'b1; ID_EX_Opcode = 5'b01100; Wsel_out = 2'b00;
    endtask

    task automatic test_reset();
        clear_inputs();
        en = 1'b0;
        rst = 1'b1;
        step(); step();
        checks++;
        if (act !== '0) begin
            errors++; $display("FAIL reset_outputs actual=%h required=0", act);
        end
        checks++;
        if (stall_out !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags actual=%b%b required=00", stall_out, redirect_valid);
        end
        rst = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_alu_ops_back_to_back();
        for (int i = 0; i < 12; i++) begin
            set_rr(alu_sel_tab[i], 5'd13, 5'd14, 5'd15, 32'hF0000003, 32'h00000024, 32'h1000 + 4 * i);
            exp_q.push_back('{alu: alu_exp_tab[i], wdata: 32'h24, pc4: 32'h1004 + 4 * i, rd: 5'd15,
                              regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
            step();
            exp = exp_q.pop_front(); last = exp;
            checks++;
            if (act !== exp) begin
                errors++; $display("FAIL alu_op_%0d actual=%h required=%h", i, act, exp);
            end
        end
    endtask

    task automatic test_add_forward();
        set_rr(4'd0, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, 32'h200);
        exp_q.push_back('{alu: 32'd7, wdata: 32'd4, pc4: 32'h204, rd: 5'd5,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
        step();
        set_rr(4'd0, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0, 32'h204);
        exp_q.push_back('{alu: 32'd14, wdata: 32'd7, pc4: 32'h208, rd: 5'd6,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL add_x5 actual=%h required=%h", act, exp);
        end
        step();
        exp = exp_q.pop_front(); last = exp;
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL add_fwd_exmem actual=%h required=%h", act, exp);
        end
    endtask

    task automatic test_fwd_priority();
        set_rr(4'd0, 5'd1, 5'd0, 5'd3, 32'd9, 32'd0, 32'h300);
        exp_q.push_back('{alu: 32'd9, wdata: 32'd0, pc4: 32'h304, rd: 5'd3,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
        step();
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL load_x3 actual=%h required=%h", act, exp);
        end
        wb_rd = 5'd3; wb_regwrite = 1'b1; wb_data = 32'd4;
        set_rr(4'd1, 5'd3, 5'd0, 5'd7, 32'd0, 32'd0, 32'h304);
        exp_q.push_back('{alu: 32'd9, wdata: 32'd0, pc4: 32'h308, rd: 5'd7,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
        step();
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL fwd_priority actual=%h required=%h", act, exp);
        end
        set_rr(4'd1, 5'd3, 5'd0, 5'd8, 32'd0, 32'd0, 32'h308);
        exp_q.push_back('{alu: 32'd4, wdata: 32'd0, pc4: 32'h30C, rd: 5'd8,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
        step();
        exp = exp_q.pop_front(); last = exp;
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL fwd_wb_only actual=%h required=%h", act, exp);
        end
        wb_regwrite = 1'b0;
    endtask

    task automatic test_load_use();
        set_rr(4'd0, 5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'h400);
        Bsel_out = 1'b1; imm_out = 32'd0; Wbsel_out = 2'b00; ID_EX_Opcode = 5'b00000;
        exp_q.push_back('{alu: 32'h100, wdata: 32'd0, pc4: 32'h404, rd: 5'd8,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b00, wsel: 2'b00});
        step();
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL load_issue actual=%h required=%h", act, exp);
        end
        set_rr(4'd0, 5'd1, 5'd8, 5'd0, 32'h100, 32'hDEAD, 32'h404);
        Bsel_out = 1'b1; imm_out = 32'd4; Wbsel_out = 2'b00; MemRw_out = 1'b1;
        IF_ID_Regwrite_out = 1'b0; ID_EX_Opcode = 5'b01000; Wsel_out = 2'b10;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++; $display("FAIL load_use_stall actual=%b required=1", stall_out);
        end
        exp_q.push_back('0);
        step();
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL load_use_bubble actual=%h required=%h", act, exp);
        end
        wb_rd = 5'd8; wb_regwrite = 1'b1; wb_data = 32'h55;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL load_use_release actual=%b required=0", stall_out);
        end
        exp_q.push_back('{alu: 32'h104, wdata: 32'h55, pc4: 32'h408, rd: 5'd0,
                          regwrite: 1'b0, memrw: 1'b1, wbsel: 2'b00, wsel: 2'b10});
        step();
        exp = exp_q.pop_front(); last = exp;
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL load_use_store actual=%h required=%h", act, exp);
        end
        wb_regwrite = 1'b0;
    endtask

    task automatic test_branch();
        clear_inputs();
        IFIDreg1_out = 5'd10; IFIDreg2_out = 5'd11;
        datareg1_out = 32'hFFFFFFFF; datareg2_out = 32'd1;
        pcx_out = 32'h100; imm_out = 32'h20; ID_EX_Opcode = 5'b11000;
        for (int r = 0; r < 8; r++) begin
            Rsel_out = 3'(r);
            #1;
            checks++;
            if (redirect_valid !== br_exp_tab[r] ||
                redirect_pc !== (br_exp_tab[r] ? 32'h120 : 32'h0)) begin
                errors++;
                $display("FAIL branch_rsel_%0d actual=%b/%h required=%b", r, redirect_valid,
                         redirect_pc, br_exp_tab[r]);
            end
        end
        Rsel_out = 3'b100;
        en = 1'b0;
        #1;
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL branch_en_low actual=%b required=0", redirect_valid);
        end
        clear_inputs();
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL bubble_quiet actual=%b%b required=00", redirect_valid, stall_out);
        end
    endtask

    task automatic test_jalr();
        clear_inputs();
        IFIDreg1_out = 5'd12; datareg1_out = 32'h203; imm_out = 32'd4; pcx_out = 32'h40;
        Bsel_out = 1'b1; ALUsel_out = 4'd0; Wbsel_out = 2'b10; IFIDregd_out = 5'd1;
        IF_ID_Regwrite_out = 1'b1; ID_EX_Opcode = 5'b11001;
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h206) begin
            errors++; $display("FAIL jalr_target actual=%b/%h required=1/206", redirect_valid, redirect_pc);
        end
        exp_q.push_back('{alu: 32'h207, wdata: 32'd0, pc4: 32'h44, rd: 5'd1,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b10, wsel: 2'b00});
        step();
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL jalr_link actual=%h required=%h", act, exp);
        end
        clear_inputs();
        ID_EX_Opcode = 5'b11011; pcx_out = 32'h40; imm_out = 32'h10;
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h50) begin
            errors++; $display("FAIL jal_target actual=%b/%h required=1/50", redirect_valid, redirect_pc);
        end
        set_rr(4'd0, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'h50);
        exp_q.push_back('{alu: 32'h44, wdata: 32'd0, pc4: 32'h54, rd: 5'd2,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
        step();
        exp = exp_q.pop_front(); last = exp;
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL fwd_pc4 actual=%h required=%h", act, exp);
        end
    endtask

    task automatic test_hold_reset();
        set_rr(4'd5, 5'd20, 5'd21, 5'd22, 32'h1234, 32'h5678, 32'h900);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (act !== last) begin
                errors++; $display("FAIL hold_cycle_%0d actual=%h required=%h", c, act, last);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (act !== '0) begin
            errors++; $display("FAIL async_reset actual=%h required=0", act);
        end
        checks++;
        if (stall_out !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags actual=%b%b required=00", stall_out, redirect_valid);
        end
        #1;
        rst = 1'b0;
        en = 1'b1;
        set_rr(4'd0, 5'd22, 5'd22, 5'd23, 32'd1, 32'd2, 32'hA00);
        exp_q.push_back('{alu: 32'd3, wdata: 32'd2, pc4: 32'hA04, rd: 5'd23,
                          regwrite: 1'b1, memrw: 1'b0, wbsel: 2'b01, wsel: 2'b00});
        step();
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL post_reset_add actual=%h required=%h", act, exp);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops_back_to_back();
        test_add_forward();
        test_fwd_priority();
        test_load_use();
        test_branch();
        test_jalr();
        test_hold_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
